// File: rtl/router_fsm.sv
// Router write-side controller: sequences header, payload, full-stall and parity phases of a packet.
// Optional macro ROUTER_PARITY_CHECK_EN adds the CHECK_PARITY_ERROR state and drives rst_int_reg.
module router_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [1:0] din,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   output logic       write_enb_reg,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       busy
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned PORTS_W = 4;

   typedef enum logic [STATE_W-1:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
`ifdef ROUTER_PARITY_CHECK_EN
      CHECK_PARITY_ERROR = 3'd6,
`endif
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   addr;
   logic [PORTS_W-1:0]  empty_vec;
   logic [PORTS_W-1:0]  soft_vec;

   logic write_enb_nxt;
   logic detect_add_nxt;
   logic lfd_nxt;
   logic ld_nxt;
   logic laf_nxt;
   logic full_nxt;
   logic busy_nxt;

   // Address 3 is not a real port: it never reads empty and has no soft reset.
   assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

   // State and captured destination address
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= DECODE_ADDRESS;
         addr  <= '0;
      end else begin
         state <= next_state;
         if (state == DECODE_ADDRESS && pkt_valid)
            addr <= din;
      end
   end

   // Next-state logic; a soft reset on the addressed port overrides everything
   always_comb begin
      next_state = state;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid && din != 2'd3)
               next_state = empty_vec[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         LOAD_FIRST_DATA: next_state = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               next_state = FIFO_FULL_STATE;
            else if (!pkt_valid)
               next_state = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               next_state = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               next_state = DECODE_ADDRESS;
            else if (low_pkt_valid)
               next_state = LOAD_PARITY;
            else
               next_state = LOAD_DATA;
         end
`ifdef ROUTER_PARITY_CHECK_EN
         LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`else
         LOAD_PARITY:
            next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`endif
         WAIT_TILL_EMPTY: begin
            if (empty_vec[addr])
               next_state = LOAD_FIRST_DATA;
         end
         default: next_state = DECODE_ADDRESS;
      endcase
      if (soft_vec[addr])
         next_state = DECODE_ADDRESS;
   end

   // Output decode of the upcoming state, so the registered outputs track the state register
   always_comb begin
      write_enb_nxt  = 1'b0;
      detect_add_nxt = 1'b0;
      lfd_nxt        = 1'b0;
      ld_nxt         = 1'b0;
      laf_nxt        = 1'b0;
      full_nxt       = 1'b0;
      busy_nxt       = 1'b1;
      case (next_state)
         DECODE_ADDRESS: begin
            detect_add_nxt = 1'b1;
            busy_nxt       = 1'b0;
         end
         LOAD_FIRST_DATA: lfd_nxt = 1'b1;
         LOAD_DATA: begin
            ld_nxt        = 1'b1;
            write_enb_nxt = 1'b1;
            busy_nxt      = 1'b0;
         end
         FIFO_FULL_STATE: full_nxt = 1'b1;
         LOAD_AFTER_FULL: begin
            laf_nxt       = 1'b1;
            write_enb_nxt = 1'b1;
         end
         LOAD_PARITY: write_enb_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         write_enb_reg <= 1'b0;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         write_enb_reg <= write_enb_nxt;
         detect_add    <= detect_add_nxt;
         lfd_state     <= lfd_nxt;
         ld_state      <= ld_nxt;
         laf_state     <= laf_nxt;
         full_state    <= full_nxt;
         busy          <= busy_nxt;
      end
   end

`ifdef ROUTER_PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst)
         rst_int_reg <= 1'b0;
      else
         rst_int_reg <= (next_state == CHECK_PARITY_ERROR);
   end
`else
   assign rst_int_reg = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed vector table, a stall-length sequence,
// and randomized traffic against a packet-level reference model.
module tb_router_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pkt_valid, parity_done, low_pkt_valid, fifo_full;
   logic [1:0] din;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
   logic       full_state, rst_int_reg, busy;
   logic [7:0] outs;

   router_fsm dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
      .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
      .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .busy(busy)
   );

   // {write_enb_reg, detect_add, lfd, ld, laf, full, rst_int_reg, busy}
   assign outs = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                  full_state, rst_int_reg, busy};

   localparam logic [7:0] E_DEC  = 8'b0100_0000;
   localparam logic [7:0] E_LFD  = 8'b0010_0001;
   localparam logic [7:0] E_LD   = 8'b1001_0000;
   localparam logic [7:0] E_FULL = 8'b0000_0101;
   localparam logic [7:0] E_LAF  = 8'b1000_1001;
   localparam logic [7:0] E_LP   = 8'b1000_0001;
   localparam logic [7:0] E_CPE  = 8'b0000_0011;
   localparam logic [7:0] E_WAIT = 8'b0000_0001;
`ifdef ROUTER_PARITY_CHECK_EN
   localparam logic [7:0] E_AFTER_LP      = E_CPE;
   localparam logic [7:0] E_AFTER_LP_FULL = E_CPE;
`else
   localparam logic [7:0] E_AFTER_LP      = E_DEC;
   localparam logic [7:0] E_AFTER_LP_FULL = E_FULL;
`endif

   typedef struct packed {
      logic       r, pv;
      logic [1:0] d;
      logic       pd, lpv, ff;
      logic [2:0] emp, sr;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [0:63];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: packet phases as names, not encodings
   typedef enum int {P_IDLE, P_HEADER, P_PAYLOAD, P_STALL, P_RESUME, P_PARITY,
                     P_CHECK, P_WAIT} phase_t;
   phase_t m_phase;
   int     m_addr;

   function automatic logic [7:0] phase_out(input phase_t p);
      case (p)
         P_IDLE:    return E_DEC;
         P_HEADER:  return E_LFD;
         P_PAYLOAD: return E_LD;
         P_STALL:   return E_FULL;
         P_RESUME:  return E_LAF;
         P_PARITY:  return E_LP;
         P_CHECK:   return E_CPE;
         default:   return E_WAIT;
      endcase
   endfunction

   task automatic model_step();
      phase_t np;
      int     na;
      logic [2:0] e;
      logic [2:0] s;
      e  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
      s  = {soft_reset_2, soft_reset_1, soft_reset_0};
      np = m_phase;
      na = m_addr;
      if (!rst) begin
         m_phase = P_IDLE;
         m_addr  = 0;
      end else begin
         if (m_phase == P_IDLE && pkt_valid) na = int'(din);
         case (m_phase)
            P_IDLE:    if (pkt_valid && din != 2'd3) np = e[din] ? P_HEADER : P_WAIT;
            P_HEADER:  np = P_PAYLOAD;
            P_PAYLOAD: np = fifo_full ? P_STALL : (pkt_valid ? P_PAYLOAD : P_PARITY);
            P_STALL:   np = fifo_full ? P_STALL : P_RESUME;
            P_RESUME:  np = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_PAYLOAD);
`ifdef ROUTER_PARITY_CHECK_EN
            P_PARITY:  np = P_CHECK;
`else
            P_PARITY:  np = fifo_full ? P_STALL : P_IDLE;
`endif
            P_CHECK:   np = fifo_full ? P_STALL : P_IDLE;
            default:   if (e[m_addr]) np = P_HEADER;
         endcase
         if (m_addr < 3 && s[m_addr]) np = P_IDLE;
         m_phase = np;
         m_addr  = na;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs %b, expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic r, pv, input logic [1:0] d, input logic pd, lpv, ff,
                        input logic [2:0] emp, sr);
      rst = r; pkt_valid = pv; din = d; parity_done = pd; low_pkt_valid = lpv;
      fifo_full = ff;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
      {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
   endtask

   task automatic add(input int r, pv, d, pd, lpv, ff, emp, sr, input logic [7:0] x);
      vecs[n_vec] = '{r: 1'(r), pv: 1'(pv), d: 2'(d), pd: 1'(pd), lpv: 1'(lpv),
                      ff: 1'(ff), emp: 3'(emp), sr: 3'(sr), exp: x};
      n_vec++;
   endtask

   initial begin
      int full_cnt;
      m_phase = P_IDLE;
      m_addr  = 0;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);

      // reset, then normal packet to port 1
      add(0,0,0,0,0,0,7,0,E_DEC);
      add(1,1,1,0,0,0,7,0,E_LFD);
      add(1,1,1,0,0,0,7,0,E_LD);
      add(1,1,1,0,0,0,7,0,E_LD);
      add(1,1,1,0,0,0,7,0,E_LD);
      add(1,0,0,0,0,0,7,0,E_LP);
      add(1,0,0,0,0,0,7,0,E_AFTER_LP);
      add(1,0,0,0,0,0,7,0,E_DEC);
      // three-cycle full stall mid-payload
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,1,0,0,0,1,7,0,E_FULL);
      add(1,1,0,0,0,1,7,0,E_FULL);
      add(1,1,0,0,0,1,7,0,E_FULL);
      add(1,1,0,0,0,0,7,0,E_LAF);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,0,0,0,0,0,7,0,E_LP);
      add(1,0,0,0,0,0,7,0,E_AFTER_LP);
      add(1,0,0,0,0,0,7,0,E_DEC);
      // port 2 not empty for five cycles
      add(1,1,2,0,0,0,3,0,E_WAIT);
      add(1,1,2,0,0,0,3,0,E_WAIT);
      add(1,1,2,0,0,0,3,0,E_WAIT);
      add(1,1,2,0,0,0,3,0,E_WAIT);
      add(1,1,2,0,0,0,3,0,E_WAIT);
      add(1,1,2,0,0,0,7,0,E_LFD);
      add(1,1,2,0,0,0,7,0,E_LD);
      // soft resets: only the addressed port counts
      add(1,1,0,0,0,0,7,1,E_LD);
      add(1,1,0,0,0,0,7,4,E_DEC);
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,1,0,0,0,0,7,1,E_DEC);
      add(1,1,1,0,0,0,7,0,E_LFD);
      add(1,1,1,0,0,0,7,0,E_LD);
      add(1,1,1,0,0,0,7,1,E_LD);
      add(1,0,1,0,0,0,7,2,E_DEC);
      // address 3 discarded
      add(1,1,3,0,0,0,7,0,E_DEC);
      add(1,1,3,0,0,0,7,0,E_DEC);
      // resume with low_pkt_valid
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,1,0,0,0,1,7,0,E_FULL);
      add(1,0,0,0,1,0,7,0,E_LAF);
      add(1,0,0,0,1,0,7,0,E_LP);
      add(1,0,0,0,0,0,7,0,E_AFTER_LP);
      add(1,0,0,0,0,0,7,0,E_DEC);
      // resume with parity_done taking priority
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,1,0,0,0,1,7,0,E_FULL);
      add(1,0,0,0,0,0,7,0,E_LAF);
      add(1,0,0,1,1,0,7,0,E_DEC);
      // fifo full after the parity byte
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(1,1,0,0,0,0,7,0,E_LD);
      add(1,0,0,0,0,0,7,0,E_LP);
      add(1,0,0,0,0,1,7,0,E_AFTER_LP_FULL);
      add(1,0,0,0,0,1,7,0,E_FULL);
      add(1,0,0,0,0,0,7,0,E_LAF);
      add(1,0,0,1,0,0,7,0,E_DEC);
      // hard reset beats soft reset and transitions
      add(1,1,0,0,0,0,7,0,E_LFD);
      add(0,1,1,0,0,1,7,7,E_DEC);
      add(1,0,0,0,0,0,6,0,E_DEC);

      for (int i = 0; i < n_vec; i++) begin
         drive(vecs[i].r, vecs[i].pv, vecs[i].d, vecs[i].pd, vecs[i].lpv, vecs[i].ff,
               vecs[i].emp, vecs[i].sr);
         step();
         check($sformatf("vec%0d", i), outs, vecs[i].exp);
      end

      // stall length: fifo_full held three cycles gives exactly three full_state cycles
      drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
      step();
      step();
      full_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         fifo_full = (c < 3);
         step();
         if (full_state) full_cnt++;
         if (c == 3) check("stall_resume", outs, E_LAF);
      end
      n_cmp++;
      if (full_cnt != 3) begin
         n_bad++;
         $display("FAIL stall_len: full_state cycles %0d, expected 3", full_cnt);
      end
      check("stall_model", outs, phase_out(m_phase));

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
               2'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), 3'($urandom),
               {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 19) == 0)});
         step();
         check($sformatf("rand%0d", c), outs, phase_out(m_phase));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
